// File: rtl/control_fsm_pkg.sv
// ============================================================================
// Module      : control_fsm_pkg
// Description : Shared control definitions: state encodings, opcodes and
//               instruction field positions for the FSM and output decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_fsm_pkg;

    localparam int INSTR_W = 23;
    localparam int CNT_W   = 16;

    // Instruction field positions
    localparam int OPC_MSB = 22;
    localparam int OPC_LSB = 20;
    localparam int RX_MSB  = 19;
    localparam int RX_LSB  = 16;
    localparam int RY_MSB  = 15;
    localparam int RY_LSB  = 12;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00000,
        ST_LOAD   = 5'b00001,
        ST_MOV    = 5'b00010,
        ST_ARITH1 = 5'b00011,
        ST_ARITH2 = 5'b00100,
        ST_ARITH3 = 5'b00101,
        ST_FETCH  = 5'b01000,
        ST_PCINC  = 5'b10000,
        ST_HALT   = 5'b11111
    } state_e;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// Module      : control_fsm
// Description : Instruction-sequencing control FSM with registered IR and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm
    import control_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               ir_valid,
    output logic               ir_req,
    output logic [4:0]         state,
    output logic [INSTR_W-1:0] instr,
    output logic               alu_op,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic               halted
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [INSTR_W-1:0]   r_ir;
    logic [CNT_W-1:0]     r_retire_cnt;
    logic                 w_ir_load;
    logic                 w_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ir         <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ir_load) begin
                r_ir <= instr_in;
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Stall indefinitely until the instruction memory responds.
                if (ir_valid) begin
                    w_ir_load = 1'b1;
                    case (opcode_of(instr_in))
                        OP_LOAD:        w_state_nxt = ST_LOAD;
                        OP_MOV:         w_state_nxt = ST_MOV;
                        OP_ADD, OP_SUB: w_state_nxt = ST_ARITH1;
                        OP_HALT:        w_state_nxt = ST_HALT;
                        default:        w_state_nxt = ST_PCINC;
                    endcase
                end
            end
            ST_LOAD:   w_state_nxt = ST_PCINC;
            ST_MOV:    w_state_nxt = ST_PCINC;
            ST_ARITH1: w_state_nxt = ST_ARITH2;
            ST_ARITH2: w_state_nxt = ST_ARITH3;
            // ARITH3 advances the PC itself, so it retires directly.
            ST_ARITH3, ST_PCINC: begin
                w_retire    = 1'b1;
                w_state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign state      = r_state;
    assign instr      = r_ir;
    assign retire_cnt = r_retire_cnt;
    assign ir_req     = (r_state == ST_FETCH);
    assign halted     = (r_state == ST_HALT);
    assign alu_op     = r_ir[OPC_LSB];

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
// Module      : tb_control_fsm
// Description : Scoreboard testbench for control_fsm with directed and
//               randomized instruction streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_control_fsm;

    localparam logic [4:0] S_IDLE  = 5'b00000;
    localparam logic [4:0] S_LOAD  = 5'b00001;
    localparam logic [4:0] S_MOV   = 5'b00010;
    localparam logic [4:0] S_A1    = 5'b00011;
    localparam logic [4:0] S_A2    = 5'b00100;
    localparam logic [4:0] S_A3    = 5'b00101;
    localparam logic [4:0] S_FETCH = 5'b01000;
    localparam logic [4:0] S_PCINC = 5'b10000;
    localparam logic [4:0] S_HALT  = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        ir_valid = 1'b0;
    logic [22:0] instr_in = '0;
    logic        ir_req;
    logic [4:0]  state;
    logic [22:0] instr;
    logic        alu_op;
    logic [15:0] retire_cnt;
    logic        halted;

    control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .instr_in   (instr_in),
        .ir_valid   (ir_valid),
        .ir_req     (ir_req),
        .state      (state),
        .instr      (instr),
        .alu_op     (alu_op),
        .retire_cnt (retire_cnt),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  st;
        logic [22:0] ir;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_trace  = 0;
    logic [22:0] m_ir  = '0;
    logic [15:0] m_cnt = '0;

    function automatic void chk(input string name, input longint unsigned got,
                                input longint unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endfunction

    // Monitor: every post-edge observation is compared against the next
    // expected architectural state queued by the stimulus.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_checks++;
            n_trace++;
            if ({state, ir_req, halted, alu_op, instr, retire_cnt} ===
                {mon_e.st, mon_e.st == S_FETCH, mon_e.st == S_HALT,
                 mon_e.ir[20], mon_e.ir, mon_e.cnt}) begin
                n_pass++;
            end else begin
                $display("FAIL trace[%0d]: got state=%b ir_req=%b halted=%b alu_op=%b instr=%h cnt=%h, want state=%b ir_req=%b halted=%b alu_op=%b instr=%h cnt=%h",
                         n_trace, state, ir_req, halted, alu_op, instr, retire_cnt,
                         mon_e.st, mon_e.st == S_FETCH, mon_e.st == S_HALT,
                         mon_e.ir[20], mon_e.ir, mon_e.cnt);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [22:0] rw();
        return 23'($urandom);
    endfunction

    // Drive one cycle of inputs (caller is at a falling edge) and queue the
    // state expected after the following rising edge.
    task automatic step(input logic r, input logic v, input logic [22:0] w,
                        input logic [4:0] s);
        exp_t e;
        run      = r;
        ir_valid = v;
        instr_in = w;
        e.st  = s;
        e.ir  = m_ir;
        e.cnt = m_cnt;
        q.push_back(e);
        @(negedge clk);
    endtask

    // One instruction starting from FETCH: optional stall, accept, execute,
    // retire. run_end is the run level seen at the instruction boundary.
    task automatic do_instr(input logic [22:0] w, input int stall, input logic run_end);
        logic [2:0] op;
        op = w[22:20];
        for (int i = 0; i < stall; i++) step(rb(), 1'b0, rw(), S_FETCH);
        m_ir = w;
        if (op == 3'b111) begin
            step(rb(), 1'b1, w, S_HALT);
        end else begin
            if (op == 3'b000 || op == 3'b001) begin
                step(rb(), 1'b1, w, (op == 3'b000) ? S_LOAD : S_MOV);
                step(rb(), rb(), rw(), S_PCINC);
            end else if (op == 3'b010 || op == 3'b011) begin
                step(rb(), 1'b1, w, S_A1);
                step(rb(), rb(), rw(), S_A2);
                step(rb(), rb(), rw(), S_A3);
            end else begin
                step(rb(), 1'b1, w, S_PCINC);
            end
            m_cnt = m_cnt + 16'd1;
            step(run_end, rb(), rw(), run_end ? S_FETCH : S_IDLE);
        end
    endtask

    task automatic resume(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) step(1'b0, rb(), rw(), S_IDLE);
        step(1'b1, rb(), rw(), S_FETCH);
    endtask

    initial begin
        logic [2:0] op;
        logic       re;

        #2 rst = 1'b1;
        #1 chk("reset_outputs", {state, instr, retire_cnt, halted, ir_req, alu_op}, 0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 1'b1, rw(), S_IDLE);
        step(1'b0, 1'b0, rw(), S_IDLE);
        step(1'b1, 1'b0, rw(), S_FETCH);

        do_instr(23'h050000, 0, 1'b1);
        do_instr(23'h214000, 0, 1'b1);
        do_instr(23'h314000, 0, 1'b1);
        do_instr(23'h123000, 5, 1'b0);
        resume(2);

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 6));
            re = ($urandom_range(0, 3) != 0);
            do_instr({op, 20'($urandom)}, $urandom_range(0, 3), re);
            if (!re) resume($urandom_range(0, 2));
        end

        while (m_cnt != 16'hFFFF) do_instr({3'b100, 20'h0}, 0, 1'b1);
        chk("retire_preload", retire_cnt, 16'hFFFF);
        do_instr({3'b110, 20'h0}, 0, 1'b1);
        chk("retire_wrap", retire_cnt, 16'h0000);

        m_ir = 23'h214000;
        step(rb(), 1'b1, m_ir, S_A1);
        step(rb(), rb(), rw(), S_A2);
        rst = 1'b1;
        #1 chk("async_reset_mid_arith", {state, instr, retire_cnt, halted, ir_req, alu_op}, 0);
        m_ir  = '0;
        m_cnt = '0;
        #1 rst = 1'b0;
        step(1'b1, rb(), rw(), S_FETCH);

        do_instr(23'h700000, 1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'(i), rw(), S_HALT);
        chk("halted_hold", halted, 1);
        rst = 1'b1;
        #1 chk("halt_reset", {state, halted, ir_req}, 0);
        m_ir  = '0;
        m_cnt = '0;
        #1 rst = 1'b0;
        step(1'b0, rb(), rw(), S_IDLE);
        step(1'b1, rb(), rw(), S_FETCH);

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
